// File: rtl/spi_sclk_gen_if.sv
// Bundle of SPI serial-clock generator signals shared with the master control FSM.
// master: control FSM side; slave: the clock generator itself.
interface spi_sclk_gen_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 5
);
    logic             EnSCLK;
    logic             EnCounter;
    logic [DIV_W-1:0] ClkDiv;
    logic             CPOL;
    logic             CPHA;
    logic             SCLK;
    logic             ShiftEdge;
    logic             SampleEdge;
    logic             WordFlg;
    logic [CNT_W-1:0] BitCnt;
    logic             SclkActive;

    modport master (
        output EnSCLK, EnCounter, ClkDiv, CPOL, CPHA,
        input  SCLK, ShiftEdge, SampleEdge, WordFlg, BitCnt, SclkActive
    );

    modport slave (
        input  EnSCLK, EnCounter, ClkDiv, CPOL, CPHA,
        output SCLK, ShiftEdge, SampleEdge, WordFlg, BitCnt, SclkActive
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock and bit-timing generator: programmable divider, CPOL/CPHA, bit counter.
// Optional feature macro SPI_SCLK_MODES_EN: when undefined the block is fixed to SPI mode 0.
module spi_sclk_gen #(
    parameter int WORD_W = 8,
    parameter int DIV_W  = 8,
    parameter int CNT_W  = 5
) (
    input  logic            clk,
    input  logic            reset,
    spi_sclk_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        TRAIL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    state_t           state_r;
    logic [DIV_W-1:0] div_reg_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic             cpol_r;
    logic             cpha_r;
    logic             sclk_r;
    logic             shift_r;
    logic             sample_r;
    logic             word_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic             active_r;

    logic             cpol_s;
    logic             cpha_s;
    logic             tick_s;
    logic             sample_go_s;
    logic             shift_go_s;

`ifdef SPI_SCLK_MODES_EN
    assign cpol_s = bus.CPOL;
    assign cpha_s = bus.CPHA;
`else
    logic unused_mode_s;
    assign unused_mode_s = bus.CPOL ^ bus.CPHA;
    assign cpol_s        = 1'b0;
    assign cpha_s        = 1'b0;
`endif

    // Edge decode: a tick is suppressed when EnSCLK drops, so an abort never strobes.
    always_comb begin
        tick_s      = 1'b0;
        sample_go_s = 1'b0;
        shift_go_s  = 1'b0;
        if ((state_r != IDLE) && bus.EnSCLK && (div_cnt_r == div_reg_r)) begin
            tick_s = 1'b1;
            if ((state_r == LEAD) != cpha_r) begin
                sample_go_s = 1'b1;
            end else begin
                shift_go_s = 1'b1;
            end
        end else begin
            tick_s      = 1'b0;
            sample_go_s = 1'b0;
            shift_go_s  = 1'b0;
        end
    end

    // Generator FSM, divider, registered SCLK/strobes and bit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            div_reg_r <= {DIV_W{1'b0}};
            div_cnt_r <= {DIV_W{1'b0}};
            cpol_r    <= 1'b0;
            cpha_r    <= 1'b0;
            sclk_r    <= 1'b0;
            shift_r   <= 1'b0;
            sample_r  <= 1'b0;
            word_r    <= 1'b0;
            bit_cnt_r <= {CNT_W{1'b0}};
            active_r  <= 1'b0;
        end else begin
            shift_r  <= shift_go_s;
            sample_r <= sample_go_s;
            word_r   <= 1'b0;

            case (state_r)
                IDLE: begin
                    sclk_r    <= cpol_s;
                    div_cnt_r <= {DIV_W{1'b0}};
                    if (bus.EnSCLK) begin
                        state_r   <= LEAD;
                        div_reg_r <= bus.ClkDiv;
                        cpol_r    <= cpol_s;
                        cpha_r    <= cpha_s;
                        active_r  <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        active_r <= 1'b0;
                    end
                end
                LEAD, TRAIL: begin
                    if (!bus.EnSCLK) begin
                        state_r   <= IDLE;
                        active_r  <= 1'b0;
                        sclk_r    <= cpol_s;
                        div_cnt_r <= {DIV_W{1'b0}};
                    end else if (tick_s) begin
                        state_r   <= (state_r == LEAD) ? TRAIL : LEAD;
                        sclk_r    <= ~sclk_r;
                        div_cnt_r <= {DIV_W{1'b0}};
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    active_r  <= 1'b0;
                    sclk_r    <= cpol_s;
                    div_cnt_r <= {DIV_W{1'b0}};
                end
            endcase

            // Counter holds through an abort unless counting is disabled.
            if (!bus.EnCounter) begin
                bit_cnt_r <= {CNT_W{1'b0}};
            end else if (sample_go_s) begin
                if (bit_cnt_r == LAST_BIT) begin
                    bit_cnt_r <= {CNT_W{1'b0}};
                    word_r    <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                end
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    assign bus.SCLK       = sclk_r;
    assign bus.ShiftEdge  = shift_r;
    assign bus.SampleEdge = sample_r;
    assign bus.WordFlg    = word_r;
    assign bus.BitCnt     = bit_cnt_r;
    assign bus.SclkActive = active_r;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: expected waveforms derived from edge-count formulas.
// Expectations follow SPI_SCLK_MODES_EN: without it every run is expected to look like mode 0.
module tb_spi_sclk_gen;

    localparam int WORD_W = 8;
    localparam int DIV_W  = 8;
    localparam int CNT_W  = 5;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_sclk_gen_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    spi_sclk_gen #(.WORD_W(WORD_W), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit eff(input bit v);
`ifdef SPI_SCLK_MODES_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_sclk"},   32'(bus.SCLK),       32'd0);
        check_eq({tag, "_shift"},  32'(bus.ShiftEdge),  32'd0);
        check_eq({tag, "_sample"}, 32'(bus.SampleEdge), 32'd0);
        check_eq({tag, "_word"},   32'(bus.WordFlg),    32'd0);
        check_eq({tag, "_bitcnt"}, 32'(bus.BitCnt),     32'd0);
        check_eq({tag, "_active"}, 32'(bus.SclkActive), 32'd0);
    endtask

    // Enable with divider n, then check every cycle k after the enable-sampling edge.
    task automatic run_seq(input int n, input bit cpol, input bit cpha, input int cycles,
                           input int chg_at, input int chg_div);
        int edges;
        int samples;
        bit strobe;
        bit leading;
        bit smp;
        bit ep;
        bit eh;
        ep = eff(cpol);
        eh = eff(cpha);
        bus.EnSCLK    = 1'b0;
        bus.EnCounter = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.ClkDiv    = DIV_W'(n);
        bus.CPOL      = cpol;
        bus.CPHA      = cpha;
        bus.EnSCLK    = 1'b1;
        bus.EnCounter = 1'b1;
        @(posedge clk);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            edges   = k / (n + 1);
            strobe  = (k > 0) && ((k % (n + 1)) == 0);
            leading = (edges % 2) == 1;
            smp     = strobe && (leading != eh);
            samples = eh ? (edges / 2) : ((edges + 1) / 2);
            check_eq($sformatf("sclk n%0d k%0d", n, k),   32'(bus.SCLK),       32'(ep ^ leading));
            check_eq($sformatf("sample n%0d k%0d", n, k), 32'(bus.SampleEdge), 32'(smp));
            check_eq($sformatf("shift n%0d k%0d", n, k),  32'(bus.ShiftEdge),  32'(strobe && !smp));
            check_eq($sformatf("word n%0d k%0d", n, k),   32'(bus.WordFlg),
                     32'(smp && ((samples % WORD_W) == 0)));
            check_eq($sformatf("bitcnt n%0d k%0d", n, k), 32'(bus.BitCnt), 32'(samples % WORD_W));
            check_eq($sformatf("active n%0d k%0d", n, k), 32'(bus.SclkActive), 32'd1);
            if (k == chg_at) begin
                bus.ClkDiv = DIV_W'(chg_div);
            end
        end
    endtask

    task automatic end_idle(input string tag);
        bus.EnSCLK    = 1'b0;
        bus.EnCounter = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_idle_active"}, 32'(bus.SclkActive), 32'd0);
        check_eq({tag, "_idle_sclk"},   32'(bus.SCLK),       32'(eff(bus.CPOL)));
        check_eq({tag, "_idle_bitcnt"}, 32'(bus.BitCnt),     32'd0);
    endtask

    initial begin
        reset         = 1'b0;
        bus.EnSCLK    = 1'b0;
        bus.EnCounter = 1'b0;
        bus.ClkDiv    = 8'd0;
        bus.CPOL      = 1'b1;
        bus.CPHA      = 1'b0;
        #12;
        check_all_zero("rst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("sclk_after_rst", 32'(bus.SCLK), 32'(eff(1'b1)));

        // Mode 0, ClkDiv=1: 4-clk period, full word plus wrap.
        run_seq(1, 1'b0, 1'b0, 64, -1, 0);
        end_idle("m0");

        // Mode 3, ClkDiv=0: toggles every clk, word every 16 clk.
        run_seq(0, 1'b1, 1'b1, 40, -1, 0);
        end_idle("m3");

        // Abort mid half-period after 3 sample edges, SCLK high at that point.
        run_seq(1, 1'b0, 1'b0, 11, -1, 0);
        bus.EnSCLK = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_sclk",   32'(bus.SCLK),       32'd0);
        check_eq("abort_sample", 32'(bus.SampleEdge), 32'd0);
        check_eq("abort_shift",  32'(bus.ShiftEdge),  32'd0);
        check_eq("abort_active", 32'(bus.SclkActive), 32'd0);
        check_eq("abort_bitcnt", 32'(bus.BitCnt),     32'd3);
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_bitcnt_hold", 32'(bus.BitCnt), 32'd3);
        bus.EnCounter = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_bitcnt_clr", 32'(bus.BitCnt), 32'd0);

        // Abort on the same edge as a sample tick: abort wins.
        run_seq(1, 1'b0, 1'b0, 10, -1, 0);
        bus.EnSCLK = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abtick_sclk",   32'(bus.SCLK),       32'd0);
        check_eq("abtick_sample", 32'(bus.SampleEdge), 32'd0);
        check_eq("abtick_shift",  32'(bus.ShiftEdge),  32'd0);
        check_eq("abtick_word",   32'(bus.WordFlg),    32'd0);
        check_eq("abtick_bitcnt", 32'(bus.BitCnt),     32'd2);
        end_idle("abtick");

        // ClkDiv 5 -> 2 mid-run is ignored; new value used after re-enable.
        run_seq(5, 1'b0, 1'b0, 30, 7, 2);
        end_idle("div5");
        run_seq(2, 1'b0, 1'b0, 20, -1, 0);
        end_idle("div2");

        // Asynchronous reset mid-word with BitCnt=5 and SCLK=1.
        run_seq(1, 1'b0, 1'b0, 19, -1, 0);
        check_eq("pre_rst_bitcnt", 32'(bus.BitCnt), 32'd5);
        check_eq("pre_rst_sclk",   32'(bus.SCLK),   32'd1);
        bus.CPOL      = 1'b1;
        bus.EnSCLK    = 1'b0;
        bus.EnCounter = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_release_sclk", 32'(bus.SCLK), 32'(eff(1'b1)));
        check_eq("midrst_release_active", 32'(bus.SclkActive), 32'd0);

        // CPOL=1/CPHA=1 with ClkDiv=1 (mode 0 when modes are compiled out).
        run_seq(1, 1'b1, 1'b1, 20, -1, 0);
        end_idle("m3d1");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
